// File: rtl/lc3b_mem_responder_if.sv
// Handshake bundle between the CPU memory port (master) and the memory responder (slave).
interface lc3b_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, proto_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Word-organised RAM answering CPU read/write requests after a fixed latency with a one-cycle
// mem_resp pulse. Define LC3B_MEM_PROTO_CHECK_EN to build the sticky request-stability checker.
module lc3b_mem_responder #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned READ_LATENCY  = 3,
  parameter int unsigned WRITE_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lc3b_mem_responder_if.slave  bus
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam int unsigned MaxLat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  localparam logic [CntW-1:0] RdCnt = CntW'(READ_LATENCY - 1);
  localparam logic [CntW-1:0] WrCnt = CntW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StRecover} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [1:0]              be_q, be_d;
  logic [15:0]             rdata_q;
  logic [15:0]             mem_q [Depth];

  logic                    req;
  logic                    enter_resp;
  logic                    ram_we;
  logic                    unused_addr;

  assign req         = bus.mem_read | bus.mem_write;
  // Bit 0 and bits above the word index alias onto the same word.
  assign unused_addr = ^{bus.mem_address[15:ADDR_WIDTH+1], bus.mem_address[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          wr_d    = ~bus.mem_read;
          idx_d   = bus.mem_address[ADDR_WIDTH:1];
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          cnt_d   = wr_d ? WrCnt : RdCnt;
          state_d = (cnt_d == '0) ? StResp : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 1'b1;
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_d == '0) begin
          state_d = StResp;
        end
      end
      StResp:    state_d = StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);
  // Gated by reset so a latency-1 request seen during reset cannot commit a write.
  assign ram_we     = enter_resp & wr_d & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      if (enter_resp && !wr_d) begin
        rdata_q <= mem_q[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (be_d[0]) mem_q[idx_d][7:0]  <= wdata_d[7:0];
      if (be_d[1]) mem_q[idx_d][15:8] <= wdata_d[15:8];
    end
  end

  assign bus.mem_resp  = (state_q == StResp);
  assign bus.mem_rdata = rdata_q;

`ifdef LC3B_MEM_PROTO_CHECK_EN
  logic [15:0] addr_q;
  logic        err_q, err_d;
  logic        mismatch;

  always_comb begin
    mismatch = 1'b0;
    if ((state_q == StBusy || state_q == StResp) && req) begin
      mismatch = (bus.mem_address != addr_q) ||
                 (bus.mem_read == wr_q) || (bus.mem_write != wr_q) ||
                 (wr_q && ((bus.mem_wdata != wdata_q) || (bus.mem_byte_enable != be_q)));
    end
    if (state_q == StIdle && bus.mem_read && bus.mem_write) begin
      mismatch = 1'b1;
    end
    err_d = err_q | mismatch;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_q == StIdle && req) begin
        addr_q <= bus.mem_address;
      end
    end
  end

  assign bus.proto_err = err_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench: timestamp-based transaction model compared every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_lc3b_mem_responder;
  localparam int unsigned AW = 10;
  localparam int unsigned RL = 3;
  localparam int unsigned WL = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lc3b_mem_responder_if mif();

  lc3b_mem_responder #(
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (mif)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit run = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request accepted at edge a answers in the cycle starting at edge a+LAT-1,
  // the responder ignores requests for two cycles after that, and drops a pending
  // request whose lines go low before the answer.
  logic [15:0] mm [2**AW];
  bit          pend = 1'b0;
  int          e = 0, acc_edge = 0, resp_edge = 0, idle_from = 0, chk_until = -1;
  bit          l_wr;
  logic [AW-1:0] l_idx;
  logic [15:0] l_addr, l_wd;
  logic [1:0]  l_be;
  logic        m_resp = 1'b0;
  logic [15:0] m_rdata = 16'h0000;
  logic        m_err = 1'b0;

  task automatic model_step();
    logic req;
    int   in_c;
    e++;
    if (!reset_n) begin
      pend = 1'b0; m_resp = 1'b0; m_rdata = 16'h0000; m_err = 1'b0;
      idle_from = 0; chk_until = -1; acc_edge = 0;
    end else begin
      in_c   = e - 1;
      req    = mif.mem_read | mif.mem_write;
      m_resp = 1'b0;
`ifdef LC3B_MEM_PROTO_CHECK_EN
      if (req && in_c >= acc_edge && in_c <= chk_until) begin
        if (mif.mem_address != l_addr || mif.mem_read == l_wr || mif.mem_write != l_wr)
          m_err = 1'b1;
        if (l_wr && (mif.mem_wdata != l_wd || mif.mem_byte_enable != l_be)) m_err = 1'b1;
      end
`endif
      if (pend && e > acc_edge && !req) begin
        pend = 1'b0; idle_from = e; chk_until = -1;
      end
      if (!pend && in_c >= idle_from && req) begin
        pend      = 1'b1;
        acc_edge  = e;
        l_wr      = !mif.mem_read;
        l_addr    = mif.mem_address;
        l_idx     = l_addr[AW:1];
        l_wd      = mif.mem_wdata;
        l_be      = mif.mem_byte_enable;
        resp_edge = e + int'(l_wr ? WL : RL) - 1;
        chk_until = resp_edge;
`ifdef LC3B_MEM_PROTO_CHECK_EN
        if (mif.mem_read && mif.mem_write) m_err = 1'b1;
`endif
      end
      if (pend && e == resp_edge) begin
        m_resp    = 1'b1;
        pend      = 1'b0;
        idle_from = e + 2;
        if (l_wr) begin
          if (l_be[0]) mm[l_idx][7:0]  = l_wd[7:0];
          if (l_be[1]) mm[l_idx][15:8] = l_wd[15:8];
        end else begin
          m_rdata = mm[l_idx];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  always @(negedge clk) begin
    if (run) begin
      check("mem_resp", {15'b0, mif.mem_resp}, {15'b0, m_resp});
      check("mem_rdata", mif.mem_rdata, m_rdata);
      check("proto_err", {15'b0, mif.proto_err}, {15'b0, m_err});
    end
  end

  task automatic drop_req();
    mif.mem_read  = 1'b0;
    mif.mem_write = 1'b0;
  endtask

  task automatic do_req(input bit rd_en, input bit wr_en, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be,
                        output logic [15:0] rdat, output int lat);
    @(posedge clk); #1;
    mif.mem_read = rd_en; mif.mem_write = wr_en; mif.mem_address = addr;
    mif.mem_wdata = wd; mif.mem_byte_enable = be;
    lat = -1;
    rdat = 16'hxxxx;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (mif.mem_resp) begin
        lat = k;
        rdat = mif.mem_rdata;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout: no mem_resp within 20 cycles for addr %h", addr);
    end
    @(posedge clk); #1;
    drop_req();
  endtask

  task automatic do_abort(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [1:0] be, input int k);
    @(posedge clk); #1;
    mif.mem_read = !wr; mif.mem_write = wr; mif.mem_address = addr;
    mif.mem_wdata = wd; mif.mem_byte_enable = be;
    repeat (k) @(posedge clk);
    #1 drop_req();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, addr, wd;
    logic [7:0]  i8;
    logic [1:0]  be;
    int          lat, cnt, k;
    bit          wr;

    drop_req();
    mif.mem_address = 16'h0; mif.mem_wdata = 16'h0; mif.mem_byte_enable = 2'b00;
    @(posedge clk);
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Fill words 0..63 with {i ^ 5A, i}.
    for (int i = 0; i < 64; i++) begin
      i8 = 8'(i);
      do_req(1'b0, 1'b1, {9'b0, i[5:0], 1'b0}, {i8 ^ 8'h5A, i8}, 2'b11, rd, lat);
    end

    // Reset during BUSY of a write aborts it.
    @(posedge clk); #1;
    mif.mem_write = 1'b1; mif.mem_address = 16'h0010; mif.mem_wdata = 16'h1234;
    mif.mem_byte_enable = 2'b11;
    @(posedge clk); #1;
    reset_n = 1'b0;
    drop_req();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, rd, lat);
    check("reset_ram8_unchanged", rd, 16'h5208);

    // Full-word write then read, both with latency 3.
    do_req(1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11, rd, lat);
    check("write_latency", 16'(lat), 16'd3);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, rd, lat);
    check("read_latency", 16'(lat), 16'd3);
    check("read_beef", rd, 16'hBEEF);

    // Byte lanes.
    do_req(1'b0, 1'b1, 16'h0020, 16'h0055, 2'b01, rd, lat);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, rd, lat);
    check("lane_low", rd, 16'hBE55);
    do_req(1'b0, 1'b1, 16'h0020, 16'hAA00, 2'b10, rd, lat);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, rd, lat);
    check("lane_high", rd, 16'hAA55);
    do_req(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b00, rd, lat);
    check("be00_latency", 16'(lat), 16'd3);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, rd, lat);
    check("be00_unchanged", rd, 16'hAA55);

    // Alias/alignment.
    do_req(1'b0, 1'b1, 16'h0801, 16'h1111, 2'b11, rd, lat);
    do_req(1'b1, 1'b0, 16'h0000, 16'h0, 2'b00, rd, lat);
    check("alias_wrap", rd, 16'h1111);

    // Abort after one BUSY cycle, then a fresh read.
    do_abort(1'b0, 16'h0020, 16'h0, 2'b00, 2);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (mif.mem_resp) cnt++;
    end
    check("abort_no_resp", 16'(cnt), 16'd0);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, rd, lat);
    check("after_abort_latency", 16'(lat), 16'd3);
    check("after_abort_data", rd, 16'hAA55);

    // Address changes during BUSY: latched address still used.
    @(posedge clk); #1;
    mif.mem_read = 1'b1; mif.mem_address = 16'h0040;
    @(posedge clk); #1;
    mif.mem_address = 16'h0042;
    lat = -1;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (mif.mem_resp) begin lat = j; rd = mif.mem_rdata; break; end
    end
    check("addr_change_latency", 16'(lat), 16'd2);
    check("addr_change_data", rd, 16'h7A20);
    @(posedge clk); #1;
    drop_req();
    repeat (3) @(posedge clk);
    #1;
`ifdef LC3B_MEM_PROTO_CHECK_EN
    check("proto_err_sticky", {15'b0, mif.proto_err}, 16'd1);
`else
    check("proto_err_tied", {15'b0, mif.proto_err}, 16'd0);
`endif

    // Read and write together: read wins, RAM untouched.
    do_req(1'b1, 1'b1, 16'h000A, 16'hFFFF, 2'b11, rd, lat);
    check("both_read_wins", rd, 16'h5F05);
    do_req(1'b1, 1'b0, 16'h000A, 16'h0, 2'b00, rd, lat);
    check("both_no_write", rd, 16'h5F05);

    // Randomised traffic over words 0..63 with random alias bits.
    for (int n = 0; n < 200; n++) begin
      wr   = 1'($urandom);
      addr = {5'($urandom), 4'b0, 6'($urandom), 1'($urandom)};
      wd   = 16'($urandom);
      be   = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 2);
        do_abort(wr, addr, wd, be, k);
      end else begin
        do_req(!wr, wr, addr, wd, be, rd, lat);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
